voice_alloc: RTL and testbench

// Polyphonic voice allocator/scheduler in front of a bank of NUM_VOICES osc instances.

---
 rtl/voice_alloc.sv | 185 ++++++++++++++++++
 tb/tb_voice_alloc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : voice_alloc
// Description : Polyphonic voice allocator. Maps note-on/note-off events onto
//               NUM_VOICES oscillator voices using retrigger > free > steal
//               oldest, with a one-voice-per-cycle scan.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BW     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    evtValid_i,
  output logic                    evtReady_o,
  input  logic                    evtNoteOn_i,
  input  logic [7:0]              evtNote_i,
  input  logic                    allOff_i,
  output logic [NUM_VOICES-1:0]   voiceEnable_o,
  output logic [8*NUM_VOICES-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]   voicePhaseRst_o,
  output logic                    stealPulse_o
);

  localparam int                IDX_BW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM_VOICES - 1);
  localparam logic [AGE_BW-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [7:0]        lat_note;
  logic              lat_on;
  logic              lat_drop;
  logic [IDX_BW-1:0] scan_idx;

  logic              match_found;
  logic [IDX_BW-1:0] match_idx;
  logic              free_found;
  logic [IDX_BW-1:0] free_idx;
  logic              old_found;
  logic [IDX_BW-1:0] old_idx;
  logic [AGE_BW-1:0] old_age;

  logic [7:0]        note_r [NUM_VOICES];
  logic [AGE_BW-1:0] age    [NUM_VOICES];

  logic              accept;
  logic              cur_en;
  logic [7:0]        cur_note;
  logic [AGE_BW-1:0] cur_age;
  logic [IDX_BW-1:0] tgt_idx;
  logic              do_steal;

  // Panic holds off new events even while the FSM sits in IDLE.
  assign evtReady_o = (state == IDLE) && !allOff_i;
  assign accept     = evtValid_i && evtReady_o;

  assign cur_en   = voiceEnable_o[scan_idx];
  assign cur_note = note_r[scan_idx];
  assign cur_age  = age[scan_idx];

  generate
    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_note_out
      assign voiceNote_o[8*k +: 8] = note_r[k];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: out-of-range notes skip the scan; panic always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = evtNote_i[7] ? APPLY : SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (allOff_i) state_nxt = IDLE;
  end

  // Note-on target: retrigger a matching voice, else lowest free, else steal oldest.
  always_comb begin
    tgt_idx  = old_idx;
    do_steal = 1'b0;
    if (match_found)     tgt_idx = match_idx;
    else if (free_found) tgt_idx = free_idx;
    else                 do_steal = old_found;
  end

  // Event latch, scan trackers and per-voice state updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_note        <= '0;
      lat_on          <= 1'b0;
      lat_drop        <= 1'b0;
      scan_idx        <= '0;
      match_found     <= 1'b0;
      match_idx       <= '0;
      free_found      <= 1'b0;
      free_idx        <= '0;
      old_found       <= 1'b0;
      old_idx         <= '0;
      old_age         <= '0;
      voiceEnable_o   <= '0;
      voicePhaseRst_o <= '0;
      stealPulse_o    <= 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        note_r[k] <= '0;
        age[k]    <= '0;
      end
    end else begin
      voicePhaseRst_o <= '0;
      stealPulse_o    <= 1'b0;
      if (allOff_i) begin
        voiceEnable_o <= '0;
        for (int k = 0; k < NUM_VOICES; k++) age[k] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              lat_note    <= evtNote_i;
              lat_on      <= evtNoteOn_i;
              lat_drop    <= evtNote_i[7];
              scan_idx    <= '0;
              match_found <= 1'b0;
              free_found  <= 1'b0;
              old_found   <= 1'b0;
            end
          end
          SCAN: begin
            if (!match_found && cur_en && (cur_note == lat_note)) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!free_found && !cur_en) begin
              free_found <= 1'b1;
              free_idx   <= scan_idx;
            end
            // Strict compare keeps the lowest index on an age tie.
            if (cur_en && (!old_found || (cur_age > old_age))) begin
              old_found <= 1'b1;
              old_idx   <= scan_idx;
              old_age   <= cur_age;
            end
            scan_idx <= scan_idx + 1'b1;
          end
          APPLY: begin
            if (!lat_drop) begin
              if (lat_on) begin
                for (int k = 0; k < NUM_VOICES; k++) begin
                  if (voiceEnable_o[k] && (IDX_BW'(k) != tgt_idx) && (age[k] != AGE_MAX))
                    age[k] <= age[k] + 1'b1;
                end
                voiceEnable_o[tgt_idx]   <= 1'b1;
                note_r[tgt_idx]          <= lat_note;
                age[tgt_idx]             <= '0;
                voicePhaseRst_o[tgt_idx] <= 1'b1;
                stealPulse_o             <= do_steal;
              end else if (match_found) begin
                voiceEnable_o[match_idx] <= 1'b0;
                age[match_idx]           <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_alloc
// Description : Directed self-checking bench for voice_alloc (NUM_VOICES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_alloc;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          evt_valid;
  logic          evt_ready;
  logic          evt_on;
  logic [7:0]    evt_note;
  logic          all_off;
  logic [NV-1:0] v_en;
  logic [8*NV-1:0] v_note;
  logic [NV-1:0] v_prst;
  logic          steal;

  int n_cmp = 0;
  int n_bad = 0;

  voice_alloc #(.NUM_VOICES(NV), .AGE_BW(4)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .evtValid_i      (evt_valid),
    .evtReady_o      (evt_ready),
    .evtNoteOn_i     (evt_on),
    .evtNote_i       (evt_note),
    .allOff_i        (all_off),
    .voiceEnable_o   (v_en),
    .voiceNote_o     (v_note),
    .voicePhaseRst_o (v_prst),
    .stealPulse_o    (steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one event for exactly one accept edge.
  task automatic send(input logic on, input logic [7:0] note);
    int t;
    t = 0;
    while (!evt_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!evt_ready) check("ready_wait", evt_ready, 1'b1);
    evt_valid = 1'b1;
    evt_on    = on;
    evt_note  = note;
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
  endtask

  // Advance to just after the APPLY edge of the event accepted last.
  task automatic settle();
    repeat (NV + 1) @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Stimulus and checks.
  initial begin
    int held60;
    rst = 1'b1; evt_valid = 1'b0; evt_on = 1'b0; evt_note = '0; all_off = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en",    v_en,      4'b0000);
    check("rst_note",  v_note,    32'h0);
    check("rst_prst",  v_prst,    4'b0000);
    check("rst_steal", steal,     1'b0);
    check("rst_ready", evt_ready, 1'b1);
    rst = 1'b0;
    next_cycle();

    // First note-on: latency and ready-low window.
    send(1'b1, 8'd60);
    for (int i = 0; i < NV + 1; i++) begin
      check("busy_ready", evt_ready, 1'b0);
      next_cycle();
    end
    check("t1_ready", evt_ready, 1'b1);
    check("t1_en",    v_en,      4'b0001);
    check("t1_note0", v_note[7:0], 8'd60);
    check("t1_prst",  v_prst,    4'b0001);
    check("t1_steal", steal,     1'b0);
    next_cycle();
    check("t1_prst_end", v_prst, 4'b0000);

    // Fill all voices, then steal the oldest.
    send(1'b1, 8'd62); settle();
    send(1'b1, 8'd64); settle();
    send(1'b1, 8'd67); settle();
    check("t2_full_en",   v_en,   4'b1111);
    check("t2_full_note", v_note, 32'h43403E3C);
    check("t2_prst3",     v_prst, 4'b1000);
    send(1'b1, 8'd69); settle();
    check("t2_steal",  steal,  1'b1);
    check("t2_prst",   v_prst, 4'b0001);
    check("t2_note",   v_note, 32'h43403E45);
    check("t2_en",     v_en,   4'b1111);
    next_cycle();
    check("t2_steal_end", steal, 1'b0);

    // Panic in the middle of a scan.
    send(1'b1, 8'd50);
    next_cycle();
    all_off = 1'b1;
    next_cycle();
    check("t5_en",        v_en,      4'b0000);
    check("t5_ready_off", evt_ready, 1'b0);
    all_off = 1'b0;
    #1;
    check("t5_ready_on",  evt_ready, 1'b1);
    repeat (6) next_cycle();
    for (int k = 0; k < NV; k++) check("t5_no50", v_note[8*k +: 8] == 8'd50, 1'b0);
    check("t5_en_hold", v_en,  4'b0000);
    check("t5_steal",   steal, 1'b0);

    // Panic with a valid event in IDLE: event must not be taken.
    all_off = 1'b1; evt_valid = 1'b1; evt_on = 1'b1; evt_note = 8'd55;
    #1;
    check("t5_ready_forced", evt_ready, 1'b0);
    repeat (2) next_cycle();
    all_off = 1'b0; evt_valid = 1'b0;
    repeat (7) next_cycle();
    check("t5_idle_en", v_en, 4'b0000);
    for (int k = 0; k < NV; k++) check("t5_no55", v_note[8*k +: 8] == 8'd55, 1'b0);

    // Retrigger an already sounding note.
    send(1'b1, 8'd60); settle();
    send(1'b1, 8'd62); settle();
    send(1'b1, 8'd60); settle();
    check("t3_prst",  v_prst, 4'b0001);
    check("t3_steal", steal,  1'b0);
    check("t3_en",    v_en,   4'b0011);
    held60 = 0;
    for (int k = 0; k < NV; k++)
      if (v_en[k] && v_note[8*k +: 8] == 8'd60) held60++;
    check("t3_one60", held60, 1);

    // Note-off present / absent, then refill lowest free voice.
    send(1'b0, 8'd62); settle();
    check("t4_en",    v_en,   4'b0001);
    check("t4_note",  v_note, 32'h43403E3C);
    check("t4_prst",  v_prst, 4'b0000);
    send(1'b0, 8'd70); settle();
    check("t4_absent_en",   v_en,   4'b0001);
    check("t4_absent_note", v_note, 32'h43403E3C);
    send(1'b1, 8'd71); settle();
    check("t4_refill_en",   v_en,   4'b0011);
    check("t4_refill_note", v_note, 32'h4340473C);
    check("t4_refill_prst", v_prst, 4'b0010);

    // Out-of-range note is dropped.
    send(1'b1, 8'd128); settle();
    check("t6_drop_en",   v_en,   4'b0011);
    check("t6_drop_note", v_note, 32'h4340473C);
    check("t6_drop_prst", v_prst, 4'b0000);
    repeat (2) next_cycle();
    check("t6_drop_ready", evt_ready, 1'b1);

    // Age saturation and lowest-index tie break.
    all_off = 1'b1;
    next_cycle();
    all_off = 1'b0;
    send(1'b1, 8'd10); settle();
    send(1'b1, 8'd11); settle();
    send(1'b1, 8'd12); settle();
    send(1'b1, 8'd13); settle();
    check("t6_fill", v_note, 32'h0D0C0B0A);
    for (int r = 0; r < 13; r++) begin
      send(1'b1, 8'd13); settle();
    end
    check("t6_retrig_prst", v_prst, 4'b1000);
    send(1'b1, 8'd20); settle();
    check("t6_sat_steal", steal,  1'b1);
    check("t6_sat_prst",  v_prst, 4'b0001);
    check("t6_sat_note",  v_note, 32'h0D0C0B14);
    send(1'b1, 8'd21); settle();
    check("t6_tie_prst", v_prst, 4'b0010);
    check("t6_tie_note", v_note, 32'h0D0C1514);
    send(1'b1, 8'd22); settle();
    check("t6_last_prst", v_prst, 4'b0100);
    check("t6_last_note", v_note, 32'h0D161514);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
